// File: rtl/alu_mul_addsub_pipe.sv
// Three-stage multiply-then-add/subtract butterfly lane: out_sum = in1 + in2*in3, out_diff = in1 - in2*in3.
// Define ALU_SAT_EN to saturate out-of-range results and raise ovf; otherwise results wrap and ovf stays 0.
module alu_mul_addsub_pipe #(
  parameter int complexnum_bit = 24,
  parameter int fp_bit         = 22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [complexnum_bit-1:0] in1,
  input  logic [complexnum_bit-1:0] in2,
  input  logic [complexnum_bit:0]   in3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [complexnum_bit-1:0] out_sum,
  output logic [complexnum_bit-1:0] out_diff,
  output logic                      ovf
);

  localparam int cb = complexnum_bit;
  localparam int pw = 2 * complexnum_bit + 1;

  // Sum/diff are formed one bit wider; a disagreement between the top two bits means overflow.
  function automatic logic range_ovf(input logic [cb:0] v);
    return v[cb] ^ v[cb-1];
  endfunction

  function automatic logic [cb-1:0] reduce(input logic [cb:0] v);
    logic [cb-1:0] r;
`ifdef ALU_SAT_EN
    if (range_ovf(v)) begin
      r = v[cb] ? {1'b1, {(cb-1){1'b0}}} : {1'b0, {(cb-1){1'b1}}};
    end else begin
      r = v[cb-1:0];
    end
`else
    r = v[cb-1:0];
`endif
    return r;
  endfunction

  logic          s1_valid_r;
  logic [cb-1:0] s1_in1_r;
  logic [cb-1:0] s1_in2_r;
  logic [cb:0]   s1_in3_r;
  logic          s2_valid_r;
  logic [cb-1:0] s2_in1_r;
  logic [cb-1:0] s2_p_r;

  logic          stall_s;
  logic [pw-1:0] prod_s;
  logic [cb-1:0] p_s;
  logic [cb:0]   sum_ext_s;
  logic [cb:0]   diff_ext_s;
  logic          ovf_s;

  // Whole pipe freezes while a finished result waits for the consumer.
  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  // Stage-2 product with truncation back to the operand fixed-point format.
  always_comb begin
    prod_s = $signed({{(pw-cb){s1_in2_r[cb-1]}}, s1_in2_r}) *
             $signed({{(pw-cb-1){s1_in3_r[cb]}}, s1_in3_r});
    p_s    = prod_s[fp_bit+cb-1:fp_bit];
  end

  // Stage-3 widened add/subtract and overflow flag (only for a valid result).
  always_comb begin
    sum_ext_s  = {s2_in1_r[cb-1], s2_in1_r} + {s2_p_r[cb-1], s2_p_r};
    diff_ext_s = {s2_in1_r[cb-1], s2_in1_r} - {s2_p_r[cb-1], s2_p_r};
`ifdef ALU_SAT_EN
    ovf_s = s2_valid_r & (range_ovf(sum_ext_s) | range_ovf(diff_ext_s));
`else
    ovf_s = 1'b0;
`endif
  end

  // Pipeline registers: all three stages advance together unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_in1_r   <= {cb{1'b0}};
      s1_in2_r   <= {cb{1'b0}};
      s1_in3_r   <= {(cb+1){1'b0}};
      s2_valid_r <= 1'b0;
      s2_in1_r   <= {cb{1'b0}};
      s2_p_r     <= {cb{1'b0}};
      out_valid  <= 1'b0;
      out_sum    <= {cb{1'b0}};
      out_diff   <= {cb{1'b0}};
      ovf        <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= in_valid;
      s1_in1_r   <= in1;
      s1_in2_r   <= in2;
      s1_in3_r   <= in3;
      s2_valid_r <= s1_valid_r;
      s2_in1_r   <= s1_in1_r;
      s2_p_r     <= p_s;
      out_valid  <= s2_valid_r;
      out_sum    <= reduce(sum_ext_s);
      out_diff   <= reduce(diff_ext_s);
      ovf        <= ovf_s;
    end
  end

endmodule

// File: tb/tb_alu_mul_addsub_pipe.sv
// Directed and randomised checks for alu_mul_addsub_pipe (cb=24, fp=22); follows ALU_SAT_EN like the design.
module tb_alu_mul_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in1;
  logic [23:0] in2;
  logic [24:0] in3;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [23:0] out_diff;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;

  alu_mul_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in3(in3), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_diff(out_diff), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic [24:0] c);
    in1 = a;
    in2 = b;
    in3 = c;
  endtask

  // Reference: packs {ovf, sum, diff} into the low 49 bits.
  function automatic logic [63:0] model(input logic [23:0] a, input logic [23:0] b, input logic [24:0] c);
    longint pr, p, s, d;
    logic [23:0] pt;
    logic o;
    pr = longint'($signed(b)) * longint'($signed(c));
    pr = pr >>> 22;
    pt = pr[23:0];
    p  = longint'($signed(pt));
    s  = longint'($signed(a)) + p;
    d  = longint'($signed(a)) - p;
    o  = 1'b0;
`ifdef ALU_SAT_EN
    if (s > 64'sd8388607) begin s = 64'sd8388607; o = 1'b1; end
    else if (s < -64'sd8388608) begin s = -64'sd8388608; o = 1'b1; end
    if (d > 64'sd8388607) begin d = 64'sd8388607; o = 1'b1; end
    else if (d < -64'sd8388608) begin d = -64'sd8388608; o = 1'b1; end
`endif
    return {15'd0, o, s[23:0], d[23:0]};
  endfunction

  logic [63:0] q[$];
  logic [63:0] pre_s;
  logic        acc, hs, stl;
  int          n_acc;
  int          budget;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(24'h0, 24'h0, 25'h0);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum_diff", {16'd0, out_sum, out_diff}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors 1-3 back to back.
    in_valid = 1'b1;
    drive(24'h100000, 24'h200000, 25'h0400000);
    cyc();
    drive(24'h000000, 24'h100000, 25'h1C00000);
    cyc();
    chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
    drive(24'h7FFFFF, 24'h200000, 25'h0400000);
    cyc();
    in_valid = 1'b0;
    chk("v1_valid", {63'd0, out_valid}, 64'd1);
    chk("v1_sum", {40'd0, out_sum}, 64'h300000);
    chk("v1_diff", {40'd0, out_diff}, 64'hF00000);
    chk("v1_ovf", {63'd0, ovf}, 64'd0);
    cyc();
    chk("v2_sum", {40'd0, out_sum}, 64'hF00000);
    chk("v2_diff", {40'd0, out_diff}, 64'h100000);
    cyc();
`ifdef ALU_SAT_EN
    chk("v3_sum", {40'd0, out_sum}, 64'h7FFFFF);
    chk("v3_ovf", {63'd0, ovf}, 64'd1);
`else
    chk("v3_sum", {40'd0, out_sum}, 64'h9FFFFF);
    chk("v3_ovf", {63'd0, ovf}, 64'd0);
`endif
    chk("v3_diff", {40'd0, out_diff}, 64'h5FFFFF);
    cyc();
    chk("bubble_valid", {63'd0, out_valid}, 64'd0);
    chk("bubble_ovf", {63'd0, ovf}, 64'd0);

    // Backpressure: four back-to-back offers with the consumer blocked.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(24'h111111, 24'h0, 25'h0);
    #1; chk("bp_rdy_a", {63'd0, in_ready}, 64'd1);
    cyc();
    drive(24'h010000, 24'h400000, 25'h0400000);
    #1; chk("bp_rdy_b", {63'd0, in_ready}, 64'd1);
    cyc();
    drive(24'h333333, 24'h0, 25'h0);
    cyc();
    chk("bp_rdy_c", {63'd0, in_ready}, 64'd0);
    drive(24'h444444, 24'h0, 25'h0);
    cyc();
    chk("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_a", {16'd0, out_sum, out_diff}, {16'd0, 24'h111111, 24'h111111});
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("bp_b", {16'd0, out_sum, out_diff}, {16'd0, 24'h410000, 24'hC10000});
    cyc();
    chk("bp_c", {16'd0, out_sum, out_diff}, {16'd0, 24'h333333, 24'h333333});
    cyc();
    chk("bp_d", {16'd0, out_sum, out_diff}, {16'd0, 24'h444444, 24'h444444});
    chk("bp_d_valid", {63'd0, out_valid}, 64'd1);
    cyc();
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Reset with three results in flight.
    in_valid = 1'b1;
    drive(24'h000001, 24'h0, 25'h0); cyc();
    drive(24'h000002, 24'h0, 25'h0); cyc();
    drive(24'h000003, 24'h0, 25'h0); cyc();
    in_valid = 1'b0;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", {15'd0, ovf, out_sum, out_diff}, 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_quiet", {63'd0, out_valid}, 64'd0);
    end

    // Random traffic against the reference, random backpressure.
    n_acc = 0;
    budget = 0;
    while ((n_acc < 100 || q.size() > 0) && budget < 3000) begin
      in_valid  = (n_acc < 100) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = $urandom_range(0, 1) != 0;
      drive($urandom(), $urandom(), $urandom());
      #1;
      acc   = in_valid & in_ready;
      hs    = out_valid & out_ready;
      stl   = out_valid & ~out_ready;
      pre_s = {15'd0, ovf, out_sum, out_diff};
      if (acc) q.push_back(model(in1, in2, in3));
      cyc();
      if (acc) n_acc++;
      if (hs) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected", 64'd1, 64'd0);
        end else begin
          chk("rnd_result", pre_s, q.pop_front());
        end
      end
      if (stl) begin
        chk("rnd_stall_valid", {63'd0, out_valid}, 64'd1);
        chk("rnd_stall_hold", {15'd0, ovf, out_sum, out_diff}, pre_s);
      end
      budget++;
    end
    chk("rnd_budget", {63'd0, budget < 3000}, 64'd1);
    chk("rnd_all_accepted", n_acc, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
